pdm_sigma_delta_tx: RTL and testbench
=====================================

Name: pdm_sigma_delta_tx

Overview:
PCM-to-PDM transmitter, the playback counterpart of the CIC PDM decimator: accepts signed PCM samples at the decimated rate and emits a 1-bit PDM stream, one bit per clk. PCM samples are buffered in a small FIFO, held or linearly interpolated to the oversampled rate, and fed to a 2nd-order sigma-delta modulator. It sits between the audio source and the PDM speaker/DAC pin, sharing the PDM clock domain.

Parameters:
OSR, 64, oversampling ratio (clk cycles per PCM sample); power of 2, ≥4; LOG2_OSR = log2(OSR).
IN_WIDTH, 16, PCM sample width (signed).
ACC_WIDTH, 24, modulator integrator width (signed).
FIFO_DEPTH, 4, input FIFO entries; power of 2.

Ports:
clk  in  1  PDM clock.
rst  in  1  reset; synchronous, active-high.
pcm_in  in  IN_WIDTH  signed PCM sample.
pcm_valid  in  1  sample present.
pcm_ready  out  1  FIFO can accept; = !rst && level<FIFO_DEPTH.
enable  in  1  modulator run.
interp_mode  in  1  0=zero-order hold, 1=linear interpolation.
pdm_out  out  1  registered PDM bit.
sample_tick  out  1  one-cycle pulse on each load cycle.
underrun  out  1  one-cycle pulse on load cycle with empty FIFO.
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: pdm_out=0, sample_tick=0, underrun=0, fifo_level=0, FIFO empty, prev=target=0, int1=int2=0, phase=OSR-1.
- FIFO: push when pcm_valid&&pcm_ready; pop only on load cycles. No bypass: push into empty FIFO in a load cycle is not popped that cycle (counts as underrun). Full FIFO with a pop in the same cycle keeps pcm_ready low that cycle. Push and pop in the same cycle leave level unchanged.
- Phase counter: counts 0..OSR-1, wraps, advances only while enable=1. Load cycle = enable && phase==OSR-1. On a load cycle: prev<=target; target<=FIFO head if non-empty; target unchanged and underrun=1 if empty; sample_tick=1; phase<=0.
- Modulator input x (IN_WIDTH+1 bits signed):
  - ZOH: x = target.
  - Linear: x = (prev*OSR + (target-prev)*phase) >>> LOG2_OSR, arithmetic (floor). This gives x=prev at phase 0.
- Modulator (every enabled cycle): FS = 2^(IN_WIDTH-1); fb = pdm_out ? +FS : -FS.
  - int1_n = sat(int1 + x - fb); int2_n = sat(int2 + int1_n - fb).
  - sat clamps to ±(2^(ACC_WIDTH-1)-1).
  - Register int1<=int1_n, int2<=int2_n, pdm_out<=(int2_n>=0).
  - A load cycle uses the x from the old phase (OSR-1); the new target takes effect from the next cycle.
- enable=0:
  - int1, int2 are cleared; phase<=OSR-1, so the first enabled cycle is a load cycle.
  - pdm_out toggles every cycle (zero-mean idle pattern).
  - The FIFO still accepts pushes.
  - sample_tick and underrun stay 0.
- interp_mode is sampled every cycle; changing it mid-period is legal and affects only x.
- Stable operation is guaranteed for |x| ≤ 0.75·FS. Larger inputs are limited only by integrator saturation, with no wrap-around.
- rst mid-operation: all state returns to reset values on the next clk edge; a pending push in that cycle is dropped.

Test Plan:
- Reset, enable=1, no pushes → underrun and sample_tick pulse in cycle 1 and every 64 cycles after; pdm_out ones count over any 64-cycle window after 256 cycles = 32±1.
- ZOH, push +16384 repeatedly to keep the FIFO non-empty → ones over 1024 cycles after settling = 768±2; underrun never pulses.
- ZOH, push -16384 repeatedly → ones over 1024 cycles = 256±2.
- enable=0, push 5 samples back-to-back with pcm_valid held → 4 accepted, pcm_ready low after 4th, fifo_level=4. Set enable=1 → sample_tick on the first enabled cycle, fifo_level=3, pcm_ready=1 the next cycle.
- Linear, prev=0 then target=16384 → x at phase k = 256·k (phase 32 → 8192). Ones in that 64-cycle period = 40±2; ZOH same stimulus → 48±2.
- Assert rst mid-stream with FIFO at 3 → next cycle pdm_out=0, fifo_level=0, pcm_ready=0 while rst high, then 1.

Source files
------------

// File: rtl/pdm_sigma_delta_tx.sv
// pdm_sigma_delta_tx: PCM-to-PDM playback transmitter.
// Signed PCM samples arrive at the decimated rate, are buffered in a small
// FIFO, held (ZOH) or linearly interpolated up to the clk rate, and drive a
// 2nd-order sigma-delta modulator producing one PDM bit per clk.
//
// Ports:
//   clk          PDM clock
//   rst          synchronous, active-high reset
//   pcm_in       signed PCM sample (IN_WIDTH)
//   pcm_valid    sample present on pcm_in
//   pcm_ready    FIFO can accept (low while rst or full)
//   enable       modulator run; when low the output idles with a toggle pattern
//   interp_mode  0 = zero-order hold, 1 = linear interpolation
//   pdm_out      registered PDM bit
//   sample_tick  one-cycle pulse on each load cycle
//   underrun     one-cycle pulse on a load cycle that found the FIFO empty
//   fifo_level   current FIFO occupancy
module pdm_sigma_delta_tx #(
  parameter int OSR        = 64,
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_WIDTH-1:0]    pcm_in,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  input  logic                          enable,
  input  logic                          interp_mode,
  output logic                          pdm_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LOG2_OSR = $clog2(OSR);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  // interpolation arithmetic: prev*OSR plus diff*phase with headroom
  localparam int XW       = IN_WIDTH + LOG2_OSR + 2;
  // modulator sums: integrator + input + feedback never exceed two extra bits
  localparam int SW       = ACC_WIDTH + 2;

  localparam logic signed [SW-1:0] FS_W = SW'(2**(IN_WIDTH-1));
  localparam logic signed [SW-1:0] AMAX = SW'(2**(ACC_WIDTH-1) - 1);

  // FIFO storage and pointers
  logic signed [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [LW-1:0]              level;

  // sample path / modulator state
  logic [LOG2_OSR-1:0]        phase;
  logic signed [IN_WIDTH-1:0] prev, target;
  logic signed [ACC_WIDTH-1:0] int1, int2;

  logic load, empty, push, pop;

  assign empty       = (level == '0);
  assign load        = enable && (phase == '1);
  assign pcm_ready   = !rst && (level < LW'(FIFO_DEPTH));
  assign push        = pcm_valid && pcm_ready;
  // no bypass: a sample pushed during a load cycle waits for the next load
  assign pop         = load && !empty;
  assign sample_tick = !rst && load;
  assign underrun    = sample_tick && empty;
  assign fifo_level  = level;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pcm_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------- modulator input ----------------
  logic signed [XW-1:0]       prev_w, diff_w, phase_w, lin_sum;
  logic signed [IN_WIDTH:0]   x;

  always_comb begin
    prev_w  = XW'(prev);
    diff_w  = XW'(target) - XW'(prev);
    phase_w = XW'({1'b0, phase});
    lin_sum = (prev_w <<< LOG2_OSR) + diff_w * phase_w;
    // arithmetic shift floors, so phase 0 yields exactly prev
    if (interp_mode) x = (IN_WIDTH+1)'(lin_sum >>> LOG2_OSR);
    else             x = (IN_WIDTH+1)'(target);
  end

  // ---------------- 2nd-order sigma-delta ----------------
  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > AMAX)       return ACC_WIDTH'(AMAX);
    else if (v < -AMAX) return ACC_WIDTH'(-AMAX);
    else                return ACC_WIDTH'(v);
  endfunction

  logic signed [SW-1:0]        fb, sum1, sum2;
  logic signed [ACC_WIDTH-1:0] int1_n, int2_n;

  always_comb begin
    fb     = pdm_out ? FS_W : -FS_W;
    sum1   = SW'(int1) + SW'(x) - fb;
    int1_n = sat(sum1);
    sum2   = SW'(int2) + SW'(int1_n) - fb;
    int2_n = sat(sum2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '1;
      prev    <= '0;
      target  <= '0;
      int1    <= '0;
      int2    <= '0;
      pdm_out <= 1'b0;
    end else if (!enable) begin
      // idle: clear integrators, arm a load for the first enabled cycle,
      // and emit a zero-mean toggle pattern
      int1    <= '0;
      int2    <= '0;
      phase   <= '1;
      pdm_out <= ~pdm_out;
    end else begin
      int1    <= int1_n;
      int2    <= int2_n;
      pdm_out <= ~int2_n[ACC_WIDTH-1];
      if (load) begin
        // this cycle's x still came from the old phase/target
        phase <= '0;
        prev  <= target;
        if (!empty) target <= mem[rd_ptr];
      end else begin
        phase <= phase + LOG2_OSR'(1);
      end
    end
  end

endmodule

// File: tb/tb_pdm_sigma_delta_tx.sv
// Testbench for pdm_sigma_delta_tx: a cycle model feeds a scoreboard of
// expected registered outputs checked every cycle, a scenario table checks
// PDM density against analytic targets, and hand sequences cover the FIFO,
// load timing and mid-stream reset corners.
module tb_pdm_sigma_delta_tx;
  localparam int OSR  = 64;
  localparam int D    = 4;
  localparam int FS   = 32768;
  localparam int AMAX = (1 << 23) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] pcm_in = '0;
  logic               pcm_valid = 1'b0;
  logic               pcm_ready;
  logic               enable = 1'b0;
  logic               interp_mode = 1'b0;
  logic               pdm_out;
  logic               sample_tick;
  logic               underrun;
  logic [2:0]         fifo_level;

  pdm_sigma_delta_tx #(.OSR(OSR), .IN_WIDTH(16), .ACC_WIDTH(24), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .enable(enable), .interp_mode(interp_mode), .pdm_out(pdm_out),
    .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int pdm; int lvl; } exp_t;
  exp_t sb[$];
  int   mq[$];
  int   m_prev, m_tgt, m_i1, m_i2, m_pdm, m_phase;
  bit   started = 1'b0;

  function automatic int msat(input int v);
    if (v > AMAX) return AMAX;
    if (v < -AMAX) return -AMAX;
    return v;
  endfunction

  function automatic int fdiv(input int n);
    if (n >= 0) return n / OSR;
    return -((-n + OSR - 1) / OSR);
  endfunction

  always @(posedge clk) begin : model
    int x, fb;
    bit push, load;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_prev = 0; m_tgt = 0; m_i1 = 0; m_i2 = 0; m_pdm = 0; m_phase = OSR - 1;
    end else begin
      push = pcm_valid && (mq.size() < D);
      load = enable && (m_phase == OSR - 1);
      x = interp_mode ? fdiv(m_prev * OSR + (m_tgt - m_prev) * m_phase) : m_tgt;
      if (enable) begin
        fb    = (m_pdm != 0) ? FS : -FS;
        m_i1  = msat(m_i1 + x - fb);
        m_i2  = msat(m_i2 + m_i1 - fb);
        m_pdm = (m_i2 >= 0) ? 1 : 0;
      end else begin
        m_i1 = 0; m_i2 = 0; m_pdm = 1 - m_pdm;
      end
      if (load) begin
        m_prev = m_tgt;
        if (mq.size() > 0) m_tgt = mq.pop_front();
        m_phase = 0;
      end else if (enable) m_phase++;
      else m_phase = OSR - 1;
      if (push) mq.push_back(int'(pcm_in));
    end
    sb.push_back('{m_pdm, mq.size()});
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    bit   tk;
    if (started) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pdm_out", 32'(pdm_out), 32'(e.pdm));
        check("fifo_level", 32'(fifo_level), 32'(e.lvl));
      end
      tk = !rst && enable && (m_phase == OSR - 1);
      check("pcm_ready", 32'(pcm_ready), 32'(!rst && (mq.size() < D)));
      check("sample_tick", 32'(sample_tick), 32'(tk));
      check("underrun", 32'(underrun), 32'(tk && (mq.size() == 0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit en, input bit mode);
    rst = 1'b1; enable = 1'b0;
    repeat (2) step();
    rst = 1'b0; enable = en; interp_mode = mode;
  endtask

  task automatic count_ones(input int n, output int ones, output int unders);
    ones = 0; unders = 0;
    repeat (n) begin
      @(negedge clk);
      ones   += int'(pdm_out);
      unders += int'(underrun);
    end
  endtask

  task automatic wait_tick(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sample_tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    bit mode; bit feed; int val; int settle; int win; int lo; int hi; int under;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int ones, unders;
    bit seen;

    tbl[0] = '{0, 0,      0, 256,   64,  31,  33,  1};
    tbl[1] = '{0, 0,      0, 301,   64,  31,  33,  1};
    tbl[2] = '{0, 1,  16384, 512, 1024, 766, 770,  0};
    tbl[3] = '{0, 1, -16384, 512, 1024, 254, 258,  0};
    tbl[4] = '{1, 1,  16384, 512, 1024, 766, 770,  0};

    repeat (2) step();

    // density scenarios
    for (int i = 0; i < 5; i++) begin
      pcm_valid = tbl[i].feed;
      pcm_in    = 16'(tbl[i].val);
      do_reset(1'b1, tbl[i].mode);
      count_ones(tbl[i].settle, ones, unders);
      count_ones(tbl[i].win, ones, unders);
      check_rng($sformatf("scen%0d_ones", i), ones, tbl[i].lo, tbl[i].hi);
      check($sformatf("scen%0d_underruns", i), 32'(unders), 32'(tbl[i].under));
    end
    pcm_valid = 1'b0;

    // load timing: tick+underrun in cycle 1, then every OSR cycles
    do_reset(1'b1, 1'b0);
    @(negedge clk);
    check("first_tick", 32'(sample_tick), 32'(1));
    check("first_underrun", 32'(underrun), 32'(1));
    @(negedge clk);
    check("tick_cycle2", 32'(sample_tick), 32'(0));
    repeat (62) @(negedge clk);
    @(negedge clk);
    check("tick_cycle65", 32'(sample_tick), 32'(1));

    // FIFO fill while disabled: 5 offered, 4 accepted
    step();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pcm_valid = 1'b1;
      pcm_in    = 16'(100 + i);
      @(negedge clk);
      check($sformatf("fill_ready%0d", i), 32'(pcm_ready), 32'(i < 4));
      step();
    end
    pcm_valid = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    check("fill_level4", 32'(fifo_level), 32'(4));
    check("fill_tick", 32'(sample_tick), 32'(1));
    check("fill_no_underrun", 32'(underrun), 32'(0));
    step();
    @(negedge clk);
    check("pop_level3", 32'(fifo_level), 32'(3));
    check("pop_ready", 32'(pcm_ready), 32'(1));

    // mid-stream reset with FIFO at 3; the push offered during rst is dropped
    step();
    rst = 1'b1; pcm_valid = 1'b1; pcm_in = 16'(555);
    @(negedge clk);
    check("rst_ready_low", 32'(pcm_ready), 32'(0));
    step();
    @(negedge clk);
    check("rst_pdm", 32'(pdm_out), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_ready_held", 32'(pcm_ready), 32'(0));
    step();
    rst = 1'b0; pcm_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(pcm_ready), 32'(1));
    check("rst_push_dropped", 32'(fifo_level), 32'(0));

    // single step 0 -> 16384: linear ramp vs hold over one period
    for (int m = 1; m >= 0; m--) begin
      step();
      do_reset(1'b1, m[0]);
      count_ones(130, ones, unders);
      step();
      pcm_valid = 1'b1; pcm_in = 16'(16384);
      step();
      pcm_valid = 1'b0;
      wait_tick(seen);
      if (seen) begin
        @(negedge clk);
        count_ones(64, ones, unders);
        if (m == 1) check_rng("lin_ramp_ones", ones, 38, 42);
        else        check_rng("zoh_step_ones", ones, 46, 50);
      end
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
